// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared widths and termination FSM encoding for the writeback stage.
package wb_stage_pkg;
   localparam int WORD = 32;
   localparam int REG_AW = 5;
   typedef enum logic [1:0] {
      WB_RUN   = 2'd0,
      WB_DRAIN = 2'd1,
      WB_DONE  = 2'd2
   } wb_state_e;
endpackage

// File: rtl/wb_stage_mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register; done > flush > stall > capture.
module mem_wb_reg #(
   parameter int WIDTH = wb_stage_pkg::WORD,
   parameter int REG_AW = wb_stage_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              done_i,
   input  logic              flush_i,
   input  logic              stall_i,
   input  logic              valid_i,
   input  logic              reg_w_i,
   input  logic              mem_to_reg_i,
   input  logic [REG_AW-1:0] rd_i,
   input  logic [WIDTH-1:0]  mem_i,
   input  logic [WIDTH-1:0]  alu_i,
   output logic              valid_o,
   output logic              reg_w_o,
   output logic              mem_to_reg_o,
   output logic [REG_AW-1:0] rd_o,
   output logic [WIDTH-1:0]  mem_o,
   output logic [WIDTH-1:0]  alu_o
);
   logic              valid_q, reg_w_q, mem_to_reg_q;
   logic [REG_AW-1:0] rd_q;
   logic [WIDTH-1:0]  mem_q, alu_q;
   logic              kill, capture;
   assign kill = done_i || flush_i;
   assign capture = !kill && !stall_i;
   // Squashing only clears valid; payload fields hold since they are don't-care.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q      <= 1'b0;
         reg_w_q      <= 1'b0;
         mem_to_reg_q <= 1'b0;
         rd_q         <= '0;
         mem_q        <= '0;
         alu_q        <= '0;
      end else begin
         valid_q <= kill ? 1'b0 : (stall_i ? valid_q : valid_i);
         if (capture) begin
            reg_w_q      <= reg_w_i;
            mem_to_reg_q <= mem_to_reg_i;
            rd_q         <= rd_i;
            mem_q        <= mem_i;
            alu_q        <= alu_i;
         end
      end
   end
   assign valid_o      = valid_q;
   assign reg_w_o      = reg_w_q;
   assign mem_to_reg_o = mem_to_reg_q;
   assign rd_o         = rd_q;
   assign mem_o        = mem_q;
   assign alu_o        = alu_q;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: final pipeline stage with writeback mux, forwarding source,
// saturating retired counter and a drain-then-halt termination FSM.
module wb_stage #(
   parameter int WIDTH = wb_stage_pkg::WORD,
   parameter int REG_AW = wb_stage_pkg::REG_AW,
   parameter int CNT_W = 32,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic              stall,
   input  logic              flush,
   input  logic              reg_w,
   input  logic              mem_to_reg,
   input  logic [REG_AW-1:0] rd_addr,
   input  logic [WIDTH-1:0]  mem_out,
   input  logic [WIDTH-1:0]  alu_out,
   input  logic              terminate,
   output logic              wb_en,
   output logic [REG_AW-1:0] wb_addr,
   output logic [WIDTH-1:0]  wb_data,
   output logic              fwd_valid,
   output logic [REG_AW-1:0] fwd_addr,
   output logic [WIDTH-1:0]  fwd_data,
   output logic [CNT_W-1:0]  retired,
   output logic              halt_done
);
   import wb_stage_pkg::*;
   localparam int DW = $clog2(DRAIN_CYCLES + 2);
   wb_state_e         state_q, state_d;
   logic [DW-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic              done, retire;
   logic              valid_q, reg_w_q, mem_to_reg_q;
   logic [REG_AW-1:0] rd_q;
   logic [WIDTH-1:0]  mem_q, alu_q;
   assign done = state_q == WB_DONE;
   assign retire = valid_in && !done && !flush && !stall;
   mem_wb_reg #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_reg (
      .clk(clk), .rst(rst), .done_i(done), .flush_i(flush), .stall_i(stall),
      .valid_i(valid_in), .reg_w_i(reg_w), .mem_to_reg_i(mem_to_reg), .rd_i(rd_addr),
      .mem_i(mem_out), .alu_i(alu_out),
      .valid_o(valid_q), .reg_w_o(reg_w_q), .mem_to_reg_o(mem_to_reg_q), .rd_o(rd_q),
      .mem_o(mem_q), .alu_o(alu_q)
   );
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      if (state_q == WB_RUN && terminate && !stall) state_d = WB_DRAIN;
      if (state_q == WB_DRAIN && !stall) begin
         cnt_d = cnt_q - DW'(1);
         state_d = (cnt_q <= DW'(1)) ? WB_DONE : WB_DRAIN;
      end
   end
   assign retired_d = (retire && retired_q != '1) ? retired_q + CNT_W'(1) : retired_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= WB_RUN;
         cnt_q     <= DW'(DRAIN_CYCLES);
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retired_q <= retired_d;
      end
   end
   assign wb_en     = valid_q && reg_w_q && (rd_q != '0);
   assign wb_addr   = rd_q;
   assign wb_data   = mem_to_reg_q ? mem_q : alu_q;
   assign fwd_valid = wb_en;
   assign fwd_addr  = wb_addr;
   assign fwd_data  = wb_data;
   assign retired   = retired_q;
   assign halt_done = done;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vectors for wb_stage, plus a CNT_W=4 instance for saturation.
module tb_wb_stage;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        rst, valid_in, stall, flush, reg_w, mem_to_reg, terminate;
   logic [4:0]  rd_addr;
   logic [31:0] mem_out, alu_out;
   logic        wb_en, fwd_valid, halt_done;
   logic [4:0]  wb_addr, fwd_addr;
   logic [31:0] wb_data, fwd_data, retired;
   logic        s_wb_en, s_fwd_valid, s_halt_done;
   logic [4:0]  s_wb_addr, s_fwd_addr;
   logic [31:0] s_wb_data, s_fwd_data;
   logic [3:0]  s_retired;
   int errors = 0;
   int checks = 0;

   wb_stage dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .flush(flush),
      .reg_w(reg_w), .mem_to_reg(mem_to_reg), .rd_addr(rd_addr), .mem_out(mem_out),
      .alu_out(alu_out), .terminate(terminate), .wb_en(wb_en), .wb_addr(wb_addr),
      .wb_data(wb_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .retired(retired), .halt_done(halt_done)
   );
   wb_stage #(.CNT_W(4)) dut_s (
      .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .flush(flush),
      .reg_w(reg_w), .mem_to_reg(mem_to_reg), .rd_addr(rd_addr), .mem_out(mem_out),
      .alu_out(alu_out), .terminate(terminate), .wb_en(s_wb_en), .wb_addr(s_wb_addr),
      .wb_data(s_wb_data), .fwd_valid(s_fwd_valid), .fwd_addr(s_fwd_addr), .fwd_data(s_fwd_data),
      .retired(s_retired), .halt_done(s_halt_done)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                        input logic [31:0] mem, input logic [31:0] alu);
      valid_in = v; reg_w = rw; mem_to_reg = m2r; rd_addr = rd; mem_out = mem; alu_out = alu;
   endtask

   task automatic wb(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d,
                     input logic [31:0] r);
      check({tag, ".wb_en"}, 64'(wb_en), 64'(en));
      check({tag, ".wb_addr"}, 64'(wb_addr), 64'(a));
      check({tag, ".wb_data"}, 64'(wb_data), 64'(d));
      check({tag, ".fwd_valid"}, 64'(fwd_valid), 64'(en));
      check({tag, ".fwd_addr"}, 64'(fwd_addr), 64'(a));
      check({tag, ".fwd_data"}, 64'(fwd_data), 64'(d));
      check({tag, ".retired"}, 64'(retired), 64'(r));
   endtask

   task automatic areset(input string tag);
      rst = 1'b0;
      #1;
      check({tag, ".wb_en"}, 64'(wb_en), 64'(0));
      check({tag, ".wb_data"}, 64'(wb_data), 64'(0));
      check({tag, ".fwd_valid"}, 64'(fwd_valid), 64'(0));
      check({tag, ".retired"}, 64'(retired), 64'(0));
      check({tag, ".halt"}, 64'(halt_done), 64'(0));
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; flush = 1'b0; terminate = 1'b0;
      drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
      #3;
      wb("reset", 0, 5'd0, 32'h0, 0);
      check("reset.halt", 64'(halt_done), 64'(0));
      @(negedge clk);
      rst = 1'b1;
      drive(1, 1, 1, 5'd5, 32'hDEADBEEF, 32'h10);
      step;
      wb("load", 1, 5'd5, 32'hDEADBEEF, 1);
      drive(1, 1, 0, 5'd0, 32'hAAAA, 32'h1234);
      step;
      wb("x0", 0, 5'd0, 32'h1234, 2);
      drive(1, 1, 0, 5'd7, 32'h0, 32'h55);
      step;
      wb("alu", 1, 5'd7, 32'h55, 3);
      stall = 1'b1;
      drive(1, 1, 1, 5'd9, 32'h99, 32'h98);
      for (int i = 0; i < 3; i++) begin
         step;
         wb("stall", 1, 5'd7, 32'h55, 3);
      end
      flush = 1'b1;
      step;
      check("flush_stall.wb_en", 64'(wb_en), 64'(0));
      check("flush_stall.fwd_valid", 64'(fwd_valid), 64'(0));
      check("flush_stall.retired", 64'(retired), 64'(3));
      stall = 1'b0;
      step;
      check("flush.wb_en", 64'(wb_en), 64'(0));
      check("flush.retired", 64'(retired), 64'(3));
      flush = 1'b0;
      drive(1, 1, 1, 5'd3, 32'h333, 32'h33);
      terminate = 1'b1;
      step;
      wb("term", 1, 5'd3, 32'h333, 4);
      check("term.halt", 64'(halt_done), 64'(0));
      terminate = 1'b0;
      valid_in = 1'b0;
      step;
      check("drain1.halt", 64'(halt_done), 64'(0));
      check("drain1.wb_en", 64'(wb_en), 64'(0));
      drive(1, 1, 0, 5'd4, 32'h0, 32'h44);
      step;
      check("drain2.halt", 64'(halt_done), 64'(1));
      wb("drain2", 1, 5'd4, 32'h44, 5);
      terminate = 1'b1;
      step;
      check("done1.halt", 64'(halt_done), 64'(1));
      check("done1.wb_en", 64'(wb_en), 64'(0));
      check("done1.retired", 64'(retired), 64'(5));
      step;
      check("done2.retired", 64'(retired), 64'(5));
      check("done2.halt", 64'(halt_done), 64'(1));
      areset("rst_done");
      valid_in = 1'b0;
      stall = 1'b1;
      step;
      check("term_stalled.halt", 64'(halt_done), 64'(0));
      stall = 1'b0;
      step;
      terminate = 1'b0;
      stall = 1'b1;
      step;
      check("sd_stall.halt", 64'(halt_done), 64'(0));
      stall = 1'b0;
      step;
      check("sd_e2.halt", 64'(halt_done), 64'(0));
      step;
      check("sd_e3.halt", 64'(halt_done), 64'(1));
      areset("rst_pre");
      drive(1, 1, 0, 5'd2, 32'h0, 32'h22);
      terminate = 1'b1;
      step;
      wb("t2", 1, 5'd2, 32'h22, 1);
      terminate = 1'b0;
      drive(1, 1, 0, 5'd6, 32'h0, 32'h66);
      step;
      wb("t2_d1", 1, 5'd6, 32'h66, 2);
      check("t2_d1.halt", 64'(halt_done), 64'(0));
      areset("rst_mid");
      valid_in = 1'b0;
      terminate = 1'b1;
      step;
      terminate = 1'b0;
      check("re_t.halt", 64'(halt_done), 64'(0));
      step;
      check("re_e1.halt", 64'(halt_done), 64'(0));
      step;
      check("re_e2.halt", 64'(halt_done), 64'(1));
      areset("rst_sat");
      drive(1, 1, 0, 5'd1, 32'h0, 32'h1);
      for (int i = 0; i < 20; i++) begin
         step;
         if (i == 13) check("sat14", 64'(s_retired), 64'(14));
      end
      check("sat.s_retired", 64'(s_retired), 64'(15));
      check("sat.retired", 64'(retired), 64'(20));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final pipeline stage, directly downstream of the MEM stage.
- Contains the MEM/WB pipeline register, the writeback select (memory data vs ALU result) and the register-file write strobe.
- Also drives the WB-side forwarding source for the EX bypass network.
- Counts retired instructions and runs a small termination FSM that drains the pipeline and raises a sticky done flag.

Parameters:
- WIDTH, `WORD, data word width.
- REG_AW, 5, register-file address width.
- CNT_W, 32, width of the retired-instruction counter.
- DRAIN_CYCLES, 2, number of advancing cycles between terminate and done.

Ports:
- clk  in  1  clock; one clock domain; all state on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- valid_in  in  1  the MEM-stage slot holds a real instruction.
- stall  in  1  hold the pipeline register (hazard unit).
- flush  in  1  squash the incoming slot.
- reg_w  in  1  the instruction writes the register file.
- mem_to_reg  in  1  1 selects mem_out, 0 selects alu_out.
- rd_addr  in  REG_AW  destination register.
- mem_out  in  WIDTH  load data from the MEM stage.
- alu_out  in  WIDTH  ALU result passed through the MEM stage.
- terminate  in  1  program end request.
- wb_en  out  1  register-file write enable.
- wb_addr  out  REG_AW  register-file write address.
- wb_data  out  WIDTH  register-file write data.
- fwd_valid  out  1  the forward path carries a live result.
- fwd_addr  out  REG_AW  forwarded destination.
- fwd_data  out  WIDTH  forwarded value.
- retired  out  CNT_W  retired-instruction count.
- halt_done  out  1  drain complete (sticky).

Behaviour:
- Reset (rst=0, asynchronous): all pipeline-register fields are 0; wb_en=0, wb_addr=0, wb_data=0, fwd_valid=0, retired=0, halt_done=0, FSM=RUN, drain counter=DRAIN_CYCLES.
- Register update priority per edge: FSM in DONE > flush > stall > capture.
  - DONE or flush: valid_q cleared; other fields don't-care but held.
  - stall: all fields hold.
  - capture: valid_q, reg_w_q, mem_to_reg_q, rd_q, mem_q and alu_q load from the inputs.
- Latency: one cycle from the MEM inputs to wb_* / fwd_*.
- wb_data = mem_to_reg_q ? mem_q : alu_q, combinational from the registers.
- wb_en = valid_q & reg_w_q & (rd_q != 0). Register 0 is never written.
- wb_en stays asserted during a stall. Rewriting the same value is harmless.
- fwd_valid, fwd_addr and fwd_data are identical to wb_en, wb_addr and wb_data. They are a separate port set so the forwarding unit has its own connection.
- retired increments by 1 on each edge that captures valid_in=1 (no stall, no flush, not DONE).
  - It saturates at 2^CNT_W-1 and does not wrap.
- FSM states: RUN, DRAIN, DONE.
  - RUN -> DRAIN when terminate=1. The instruction present on that edge is still captured.
  - DRAIN: the drain counter decrements on each non-stall edge. At 0 -> DONE.
  - DONE: halt_done=1. No further captures or retirements. wb_en falls to 0 one cycle after entry. Exit only by reset.
  - terminate re-asserted in DRAIN or DONE has no effect. terminate is ignored while stall=1 in RUN; it is sampled again on the next edge.
- Simultaneous flush and stall: flush wins and the slot is squashed.
- Reset mid-drain: returns to RUN with the counter reloaded.

Decomposition:
- Shared package / constants.v:
  - WORD and REG_AW.
  - FSM state encodings WB_RUN=2'd0, WB_DRAIN=2'd1, WB_DONE=2'd2.
- Natural sub-module: mem_wb_reg, the pipeline register with its flush/stall/capture priority.
- wb_stage instantiates mem_wb_reg and adds the writeback mux, retired counter and termination FSM.

Test Plan:
- Reset then a load: reset, then valid_in=1, reg_w=1, mem_to_reg=1, rd_addr=5, mem_out=0xDEADBEEF, alu_out=0x10 -> next cycle wb_en=1, wb_addr=5, wb_data=0xDEADBEEF, fwd_* identical, retired=1.
- ALU op and x0 guard: mem_to_reg=0, alu_out=0x1234, rd_addr=0 -> wb_en=0, fwd_valid=0, wb_data=0x1234, retired still increments.
- Stall/flush: stall=1 for 3 cycles with new inputs applied -> outputs held and retired unchanged. Then flush=1 with stall=1 -> wb_en=0 next cycle and retired unchanged.
- Termination: terminate=1 while valid_in=1 -> that instruction retires. halt_done=1 after exactly 2 further non-stall edges. With one stall inserted during DRAIN -> 3 edges. Later inputs are not retired.
- Saturation: CNT_W=4, 20 back-to-back valid captures -> retired stops at 15.
- Asynchronous reset mid-DRAIN: pull rst low between clock edges -> all outputs 0 immediately, FSM=RUN. After release, a new terminate needs the full 2 edges.
